pht_counter_array: RTL
======================

Name: pht_counter_array

Overview:
- Parametrised pattern history table of saturating branch counters.
- Generalises the single 2-bit predictor counter to NUM_ENTRIES counters of CTR_BITS each.
- Provides NUM_READ combinational prediction lanes for the superscalar fetch stage and one update port from branch resolution.
- Adds a multi-cycle table-clear sweep, used on context switch, that is controlled by a small FSM.

Parameters:
- NUM_ENTRIES, 64, number of counters; power of two, ≥2; IDX_W = $clog2(NUM_ENTRIES).
- CTR_BITS, 2, counter width; ≥1; CTR_MAX = 2^CTR_BITS − 1.
- NUM_READ, 2, number of independent prediction read lanes; ≥1.
- INIT_CTR, 0, value loaded by reset and by the sweep (0 = strongly not-taken); must be ≤ CTR_MAX.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset, sampled on posedge clock.
- rd_idx  in  NUM_READ×IDX_W  per-lane table index.
- pred  out  NUM_READ  per-lane prediction, 1 = taken.
- pred_strong  out  NUM_READ  per-lane flag: the counter read is at 0 or CTR_MAX.
- upd_valid  in  1  apply a resolved-branch update this cycle.
- upd_idx  in  IDX_W  entry to update.
- upd_taken  in  1  resolved direction.
- clear  in  1  request a full-table reinitialisation sweep.
- busy  out  1  sweep in progress.

Behaviour:
- Reset (reset==0 at posedge):
  - All NUM_ENTRIES counters are set to INIT_CTR.
  - FSM goes to IDLE; sweep pointer goes to 0.
  - busy = 0.
  - With default INIT_CTR, pred = 0 and pred_strong = 1 on all lanes.
  - Reset wins over every other input, including mid-sweep.
- Read path:
  - Purely combinational, 0-cycle latency.
  - pred[i] = MSB of ctr[rd_idx[i]].
  - pred_strong[i] = (ctr == 0) || (ctr == CTR_MAX).
  - Lanes are independent; identical indices on several lanes are legal and return identical values.
- Update, applied at posedge when upd_valid && state==IDLE:
  - Taken: ctr = (ctr == CTR_MAX) ? CTR_MAX : ctr + 1.
  - Not taken: ctr = (ctr == 0) ? 0 : ctr − 1.
  - No wrap-around in either direction.
  - Only entry upd_idx changes; all other entries hold.
- FSM states: IDLE, SWEEP.
  - IDLE → SWEEP when clear==1. The update in that same cycle is still applied. Sweep pointer loads 0.
  - SWEEP: each cycle writes INIT_CTR to entry ptr, then ptr increments.
  - SWEEP → IDLE after entry NUM_ENTRIES−1 is written. The sweep lasts exactly NUM_ENTRIES cycles.
  - clear is ignored while in SWEEP; the sweep does not restart.
  - upd_valid is ignored and dropped while in SWEEP; the requester must stall on busy.
  - busy = 1 exactly while state==SWEEP.
  - During SWEEP, pred and pred_strong are forced to 0 on every lane, regardless of table contents.
- Simultaneous read and update to the same index: the read returns the pre-update value, unless the optional feature below is enabled.
- Storage is a flat register array; no SRAM macro.

Optional Feature:
- Macro: PHT_UPD_BYPASS_EN.
- Defined:
  - When upd_valid, state==IDLE and rd_idx[i]==upd_idx, lane i returns pred and pred_strong computed from the post-update (next-state) counter value in the same cycle.
  - Adds a combinational path from the upd_* inputs to pred.
- Undefined:
  - Lanes always read the registered counter value.
  - The update becomes visible one cycle after its posedge.

Test Plan:
- Reset then read: after reset=0 for 1 cycle, read idx 0 and idx 63 → pred=0, pred_strong=1, busy=0.
- Saturation up: 4 taken updates to idx 5 → counter sequence 0,1,2,3,3; pred goes 1 after the 2nd update; pred_strong=1 only at 3. Then 1 not-taken → counter=2, pred=1, pred_strong=0.
- Saturation down / isolation: 2 not-taken updates to idx 7 from 0 → stays 0. Idx 6 and idx 8 are unchanged after the idx 5 updates.
- Same-cycle read/update: ctr[9]=1, update taken at idx 9, read idx 9 in the same cycle:
  - Without the macro → pred=0 that cycle, pred=1 the next cycle.
  - With PHT_UPD_BYPASS_EN → pred=1 that cycle.
- Clear sweep: set idx 0, 31 and 63 to 3, pulse clear → busy=1 for exactly 64 cycles; pred=0 throughout. An update issued mid-sweep is dropped. Afterwards all three entries read 0.
- Reset mid-sweep: assert reset 10 cycles into a sweep → busy=0 the next cycle, all entries=INIT_CTR, a new clear starts a full 64-cycle sweep.

Source files
------------

// File: rtl/pht_counter_array.sv
// pht_counter_array
//
// Pattern history table of NUM_ENTRIES saturating branch counters, each
// CTR_BITS wide. It has NUM_READ independent combinational prediction lanes
// and one update port from branch resolution. A clear request starts a sweep
// that rewrites every entry with INIT_CTR, one entry per cycle.
//
// Ports:
//   clock        in   system clock, all state changes on posedge
//   reset        in   synchronous active-low reset
//   rd_idx       in   NUM_READ x IDX_W packed per-lane table index (lane 0 in LSBs)
//   pred         out  NUM_READ per-lane prediction (1 = taken)
//   pred_strong  out  NUM_READ per-lane flag: counter is at 0 or CTR_MAX
//   upd_valid    in   apply a resolved-branch update this cycle
//   upd_idx      in   entry to update
//   upd_taken    in   resolved direction
//   clear        in   request a full-table reinitialisation sweep
//   busy         out  sweep in progress
//
// Optional feature macro: PHT_UPD_BYPASS_EN
//   When defined, a lane whose index matches an accepted update returns the
//   post-update counter in the same cycle. When undefined, lanes always read
//   the stored counter, so an update becomes visible one cycle later.

module pht_counter_array #(
    parameter int NUM_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int NUM_READ    = 2,
    parameter int INIT_CTR    = 0,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_READ*IDX_W-1:0] rd_idx,
    output logic [NUM_READ-1:0]       pred,
    output logic [NUM_READ-1:0]       pred_strong,
    input  logic                      upd_valid,
    input  logic [IDX_W-1:0]          upd_idx,
    input  logic                      upd_taken,
    input  logic                      clear,
    output logic                      busy
);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(INIT_CTR);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   ptr_reg;

    logic [CTR_BITS-1:0] ctr_val [NUM_ENTRIES];
    logic [CTR_BITS-1:0] upd_cur;
    logic [CTR_BITS-1:0] upd_val;
    logic                upd_we;
    logic                sweep_we;

    assign sweep_we = (state_reg == SWEEP);
    // Updates arriving during a sweep are dropped; the requester stalls on busy.
    assign upd_we   = upd_valid && (state_reg == IDLE);
    assign busy     = sweep_we;

    // Saturating next value for the entry being updated.
    assign upd_cur = ctr_val[upd_idx];
    always_comb begin
        upd_val = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) begin
                upd_val = upd_cur + 1'b1;
            end
        end else begin
            if (upd_cur != '0) begin
                upd_val = upd_cur - 1'b1;
            end
        end
    end

    // Sweep controller. The pointer wraps back to 0 after the last entry,
    // which is also when the sweep returns to IDLE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        state_reg <= SWEEP;
                        ptr_reg   <= '0;
                    end
                end
                SWEEP: begin
                    if (ptr_reg == LAST_IDX) begin
                        state_reg <= IDLE;
                    end
                    ptr_reg <= ptr_reg + 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ptr_reg   <= '0;
                end
            endcase
        end
    end

    // Counter storage: one register per entry with its own write decode.
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        logic [CTR_BITS-1:0] ctr_reg;

        always_ff @(posedge clock) begin
            if (!reset) begin
                ctr_reg <= INIT_VAL;
            end else if (sweep_we && (ptr_reg == IDX_W'(gi))) begin
                ctr_reg <= INIT_VAL;
            end else if (upd_we && (upd_idx == IDX_W'(gi))) begin
                ctr_reg <= upd_val;
            end
        end

        assign ctr_val[gi] = ctr_reg;
    end

    // Prediction lanes. Outputs are forced low while the table is being swept.
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_lane
        logic [IDX_W-1:0]    idx;
        logic [CTR_BITS-1:0] val;

        assign idx = rd_idx[gi*IDX_W +: IDX_W];

        always_comb begin
            val = ctr_val[idx];
`ifdef PHT_UPD_BYPASS_EN
            if (upd_we && (idx == upd_idx)) begin
                val = upd_val;
            end
`endif
        end

        assign pred[gi]        = !sweep_we && val[CTR_BITS-1];
        assign pred_strong[gi] = !sweep_we && ((val == '0) || (val == CTR_MAX));
    end

endmodule
